// File: rtl/delay_pipe_arbiter.sv
// delay_pipe_arbiter: round-robin arbiter that shares one fixed-latency delay
// pipeline between N_REQ requesters. A tag shift register that runs in step
// with the pipeline routes each returning word to the requester that issued it.
// A small flush FSM stops issue and reports when the pipeline has drained.
module delay_pipe_arbiter #(
    parameter int BUS_WIDTH = 32,
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int DELAY_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ*BUS_WIDTH-1:0] i_req_data,
    input  logic [N_REQ-1:0]           i_req_valid,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic [N_REQ-1:0]           i_req_enable,
    output logic [BUS_WIDTH-1:0]       o_pipe_in_data,
    output logic                       o_pipe_in_valid,
    input  logic [BUS_WIDTH-1:0]       i_pipe_out_data,
    input  logic                       i_pipe_out_valid,
    output logic [BUS_WIDTH-1:0]       o_rsp_data,
    output logic [N_REQ-1:0]           o_rsp_valid,
    input  logic                       i_flush_req,
    output logic                       o_flush_done,
    output logic                       o_busy,
    output logic                       o_err_orphan
);

    localparam int CNT_W = $clog2(DELAY_LEN + 2);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_t                r_state, w_state_next;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_pipe_in_idx;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic                  r_err;
    tag_t                  r_tags [DELAY_LEN];
    tag_t                  w_tag_last;
    logic [N_REQ-1:0]      w_eligible;
    logic [N_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_grant_any;
    logic [BUS_WIDTH-1:0]  w_grant_data;
    logic                  w_orphan;

    // (base + k) mod N_REQ for 0 <= k < N_REQ; safe for non power-of-two N_REQ
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Round-robin pick: first eligible requester at or after the pointer
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        w_eligible  = i_req_valid & i_req_enable;
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        // Reset is checked here too so req_ready reads 0 while rst is held.
        if (!rst && r_state == ST_RUN && !i_flush_req) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!w_grant_any && w_eligible[wrap_idx(r_ptr, k)]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = wrap_idx(r_ptr, k);
                end
            end
            if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign o_req_ready = w_grant;

    // Select the granted requester's word for the pipeline input register
    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) w_grant_data = i_req_data[k*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    // Pipeline input register and round-robin pointer; data holds when idle
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_ptr           <= '0;
            o_pipe_in_valid <= 1'b0;
            o_pipe_in_data  <= '0;
            r_pipe_in_idx   <= '0;
        end else begin
            o_pipe_in_valid <= w_grant_any;
            if (w_grant_any) begin
                r_ptr          <= wrap_idx(w_grant_idx, 1);
                o_pipe_in_data <= w_grant_data;
                r_pipe_in_idx  <= w_grant_idx;
            end
        end
    end

    // Tag shift register, advancing in lock-step with the shared pipeline
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the tag array is reset explicitly; a stale valid tag after reset would route a phantom response.
        if (rst) begin
            for (int k = 0; k < DELAY_LEN; k++) r_tags[k] <= '0;
        end else begin
            r_tags[0] <= '{valid: o_pipe_in_valid, idx: r_pipe_in_idx};
            for (int k = 1; k < DELAY_LEN; k++) r_tags[k] <= r_tags[k-1];
        end
    end

    assign w_tag_last = r_tags[DELAY_LEN-1];
    assign o_rsp_data = i_pipe_out_data;

    // Route a returning word to the requester named by the last tag stage
    always_comb begin
        o_rsp_valid = '0;
        if (i_pipe_out_valid && w_tag_last.valid) o_rsp_valid[w_tag_last.idx] = 1'b1;
    end

    // In-flight count: issue increments, return decrements, underflow flags an orphan
    always_comb begin
        w_cnt_next = r_cnt;
        w_orphan   = 1'b0;
        if (o_pipe_in_valid && !i_pipe_out_valid) begin
            w_cnt_next = r_cnt + 1'b1;
        end else if (!o_pipe_in_valid && i_pipe_out_valid) begin
            if (r_cnt == '0) w_orphan = 1'b1;
            else             w_cnt_next = r_cnt - 1'b1;
        end
    end

    // Counter, sticky orphan flag and FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_cnt   <= w_cnt_next;
            r_err   <= r_err | w_orphan;
            r_state <= w_state_next;
        end
    end

    // Flush FSM next state. DRAIN looks at the post-edge count so DONE lands in
    // the cycle right after the last response, when busy also falls.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_RUN:   if (i_flush_req) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_cnt_next == '0 && !w_grant_any) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    assign o_flush_done = (r_state == ST_DONE);
    assign o_busy       = (r_cnt != '0);
    assign o_err_orphan = r_err;

endmodule

// File: tb/tb_delay_pipe_arbiter.sv
// Self-checking bench for delay_pipe_arbiter. It models the shared delay pipeline,
// tracks expected arbitration/flush/counter behaviour cycle by cycle, and uses a
// scoreboard queue: each transfer pushes {requester, data, cycle}, each response pops.
module tb_delay_pipe_arbiter;

    localparam int BW = 32;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DL = 4;

    typedef enum int {S_RUN, S_DRAIN, S_DONE} mstate_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*BW-1:0]   req_data;
    logic [N-1:0]      req_valid, req_ready, req_enable;
    logic [BW-1:0]     pipe_in_data, pipe_out_data, rsp_data;
    logic              pipe_in_valid, pipe_out_valid;
    logic [N-1:0]      rsp_valid;
    logic              flush_req, flush_done, busy, err_orphan;
    logic              inj;

    logic [BW-1:0]     p_data  [DL];
    logic              p_valid [DL];

    int      n_assert = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    int      last_rsp_cyc = 0;
    int      done_cyc = 0;
    bit      done_seen = 0;

    exp_t    sb[$];
    int      m_ptr, m_cnt, m_err;
    logic    m_piv;
    logic [BW-1:0] m_pid;
    mstate_t m_state;

    delay_pipe_arbiter #(.BUS_WIDTH(BW), .N_REQ(N), .IDX_W(IW), .DELAY_LEN(DL)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_data       (req_data),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_enable     (req_enable),
        .o_pipe_in_data   (pipe_in_data),
        .o_pipe_in_valid  (pipe_in_valid),
        .i_pipe_out_data  (pipe_out_data),
        .i_pipe_out_valid (pipe_out_valid),
        .o_rsp_data       (rsp_data),
        .o_rsp_valid      (rsp_valid),
        .i_flush_req      (flush_req),
        .o_flush_done     (flush_done),
        .o_busy           (busy),
        .o_err_orphan     (err_orphan)
    );

    always #5 clk = ~clk;

    // Shared delay pipeline model, reset together with the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DL; k++) begin
                p_data[k]  <= '0;
                p_valid[k] <= 1'b0;
            end
        end else begin
            p_data[0]  <= pipe_in_data;
            p_valid[0] <= pipe_in_valid;
            for (int k = 1; k < DL; k++) begin
                p_data[k]  <= p_data[k-1];
                p_valid[k] <= p_valid[k-1];
            end
        end
    end

    assign pipe_out_data  = p_data[DL-1];
    assign pipe_out_valid = p_valid[DL-1] | inj;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] e, input int p);
        for (int k = 0; k < N; k++) begin
            if (e[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Monitor: compare outputs against the model away from the rising edge
    always @(negedge clk) begin : mon
        int            g;
        int            cnt_n;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rsp;
        exp_t          e;
        cyc++;
        if (rst) begin
            check("rst_ready",         64'(req_ready),     64'(0));
            check("rst_pipe_in_valid", 64'(pipe_in_valid), 64'(0));
            check("rst_pipe_in_data",  64'(pipe_in_data),  64'(0));
            check("rst_flush_done",    64'(flush_done),    64'(0));
            check("rst_busy",          64'(busy),          64'(0));
            check("rst_err_orphan",    64'(err_orphan),    64'(0));
            check("rst_rsp_valid",     64'(rsp_valid),     64'(0));
            m_ptr = 0; m_cnt = 0; m_err = 0; m_piv = 1'b0; m_pid = '0; m_state = S_RUN;
            sb.delete();
        end else begin
            g = (m_state == S_RUN && !flush_req) ? rr_pick(req_valid & req_enable, m_ptr) : -1;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("ready",         64'(req_ready),     64'(exp_ready));
            check("pipe_in_valid", 64'(pipe_in_valid), 64'(m_piv));
            check("pipe_in_data",  64'(pipe_in_data),  64'(m_pid));
            check("flush_done",    64'(flush_done),    64'(m_state == S_DONE));
            check("busy",          64'(busy),          64'(m_cnt != 0));
            check("err_orphan",    64'(err_orphan),    64'(m_err));

            if (p_valid[DL-1]) begin
                last_rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    check("rsp_without_issue", 64'(sb.size()), 64'(1));
                end else begin
                    e = sb.pop_front();
                    exp_rsp = '0;
                    exp_rsp[e.idx] = 1'b1;
                    check("rsp_valid",   64'(rsp_valid),   64'(exp_rsp));
                    check("rsp_data",    64'(rsp_data),    64'(e.data));
                    check("rsp_latency", 64'(cyc - e.cyc), 64'(DL + 1));
                end
            end else if (!inj) begin
                check("rsp_idle", 64'(rsp_valid), 64'(0));
            end

            if (flush_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end

            // Advance the model by one clock edge
            cnt_n = m_cnt;
            if (m_piv && !pipe_out_valid) cnt_n = m_cnt + 1;
            else if (!m_piv && pipe_out_valid) begin
                if (m_cnt == 0) m_err = 1;
                else            cnt_n = m_cnt - 1;
            end
            case (m_state)
                S_RUN:   if (flush_req) m_state = S_DRAIN;
                S_DRAIN: if (cnt_n == 0 && g < 0) m_state = S_DONE;
                default: m_state = S_RUN;
            endcase
            m_cnt = cnt_n;
            m_piv = (g >= 0);
            if (g >= 0) begin
                m_pid = req_data[g*BW +: BW];
                sb.push_back('{idx: g, data: req_data[g*BW +: BW], cyc: cyc});
                m_ptr = (g + 1) % N;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_words();
        for (int i = 0; i < N; i++) req_data[i*BW +: BW] = $urandom;
    endtask

    initial begin
        rst = 1'b1; req_data = '0; req_valid = '0; req_enable = '0;
        flush_req = 1'b0; inj = 1'b0;
        tick(3);
        rst = 1'b0;

        // Idle after reset
        tick(5);

        // Lone requester 1 with a known word
        req_enable = '1;
        req_data[1*BW +: BW] = 32'hA5A5_A5A5;
        req_valid = 4'b0010;
        tick(1);
        req_valid = '0;
        tick(10);

        // All requesters continuously, then requester 2 masked off
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin rand_words(); tick(1); end
        req_enable = 4'b1011;
        for (int i = 0; i < 8; i++) begin rand_words(); tick(1); end
        req_enable = '1;
        // Reset in the middle of a stream
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin rand_words(); tick(1); end
        req_valid = '0;
        tick(10);

        // Flush with four words in flight; requesters stay valid during the drain
        req_valid = '1;
        for (int i = 0; i < 4; i++) begin rand_words(); tick(1); end
        done_seen = 1'b0;
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) tick(1);
        req_valid = '0;
        check("flush_done_seen", 64'(done_seen), 64'(1));
        check("flush_done_after_last_rsp", 64'(done_cyc - last_rsp_cyc), 64'(1));
        tick(10);

        // Orphan response with nothing in flight
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        tick(5);
        check("orphan_sticky", 64'(err_orphan), 64'(1));
        check("orphan_busy",   64'(busy),       64'(0));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        check("orphan_cleared", 64'(err_orphan), 64'(0));

        // Random traffic with occasional flushes and one reset
        for (int i = 0; i < 400; i++) begin
            rand_words();
            req_valid  = N'($urandom);
            req_enable = N'($urandom) | N'($urandom);
            flush_req  = ($urandom_range(0, 29) == 0);
            rst        = (i == 200);
            tick(1);
        end
        rst = 1'b0; req_valid = '0; flush_req = 1'b0;
        tick(15);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
